// File: rtl/screen_loader_if.sv
// screen_loader_if: groups the control, ROM and VGA plot signals around the screen loader
// master: control FSM / ROM mux side; drives start, memory_select and rom_data, and receives the rest
// slave : screen loader side; drives rom_sel, rom_addr, x, y, colour, plot, busy and finished
interface screen_loader_if #(
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [1:0]          memory_select;
    logic [1:0]          rom_sel;
    logic [ADDR_W-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_data;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                finished;
    modport master (
        output start, memory_select, rom_data,
        input  rom_sel, rom_addr, x, y, colour, plot, busy, finished
    );
    modport slave (
        input  start, memory_select, rom_data,
        output rom_sel, rom_addr, x, y, colour, plot, busy, finished
    );
endinterface

// File: rtl/screen_loader.sv
// screen_loader: on start, streams one full-screen background image from the selected ROM to the VGA plot port
// Ports:
//   clock  - system clock
//   resetn - asynchronous active-low reset
//   bus    - screen_loader_if.slave: start/memory_select request, rom_sel/rom_addr/rom_data ROM port,
//            x/y/colour/plot VGA port, busy level and one-cycle finished pulse
module screen_loader #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int ADDR_W       = 15,
    parameter int COLOUR_W     = 3,
    parameter int BLANK_COLOUR = 0
) (
    input  logic clock,
    input  logic resetn,
    screen_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t              state, state_n;
    logic [7:0]          fx, fx_n, x_q, x_n;
    logic [6:0]          fy, fy_n, y_q, y_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [1:0]          sel_q, sel_n;
    logic [COLOUR_W-1:0] colour_q, colour_n;
    logic                plot_q, plot_n, busy_q, busy_n, fin_q, fin_n;
    logic                row_end, last;
    assign row_end = fx == 8'(WIDTH - 1);
    assign last    = row_end && fy == 7'(HEIGHT - 1);
    always_comb begin
        state_n  = state;
        fx_n     = fx;
        fy_n     = fy;
        addr_n   = addr_q;
        sel_n    = sel_q;
        x_n      = x_q;
        y_n      = y_q;
        colour_n = colour_q;
        plot_n   = 1'b0;
        busy_n   = busy_q;
        fin_n    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                sel_n   = bus.memory_select;
                addr_n  = '0;
                fx_n    = '0;
                fy_n    = '0;
                busy_n  = 1'b1;
                state_n = FETCH;
            end
            FETCH: begin
                // rom_data belongs to the fetch point held during this cycle
                plot_n   = 1'b1;
                x_n      = fx;
                y_n      = fy;
                colour_n = sel_q == 2'd3 ? COLOUR_W'(BLANK_COLOUR) : bus.rom_data;
                // the last fetch point is not advanced so rom_addr holds N-1 to the end
                state_n  = last ? DRAIN : FETCH;
                fx_n     = last ? fx : row_end ? 8'd0 : fx + 8'd1;
                fy_n     = last ? fy : row_end ? fy + 7'd1 : fy;
                addr_n   = last ? addr_q : addr_q + ADDR_W'(1);
            end
            DRAIN: begin
                busy_n  = 1'b0;
                fin_n   = 1'b1;
                state_n = DONE;
            end
            DONE: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            state    <= IDLE;
            fx       <= '0;
            fy       <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state    <= state_n;
            fx       <= fx_n;
            fy       <= fy_n;
            addr_q   <= addr_n;
            sel_q    <= sel_n;
            x_q      <= x_n;
            y_q      <= y_n;
            colour_q <= colour_n;
            plot_q   <= plot_n;
            busy_q   <= busy_n;
            fin_q    <= fin_n;
        end
    assign bus.rom_sel  = sel_q;
    assign bus.rom_addr = addr_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
    assign bus.busy     = busy_q;
    assign bus.finished = fin_q;
endmodule

// File: tb/tb_screen_loader.sv
// tb_screen_loader: table-driven and sequence checks of screen_loader against a pixel/colour model
module tb_screen_loader;
    localparam int N = 19200;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    int pix_fail = 0;
    always #5 clock = ~clock;
    screen_loader_if #(.ADDR_W(15), .COLOUR_W(3)) bus();
    screen_loader #(.WIDTH(160), .HEIGHT(120), .ADDR_W(15), .COLOUR_W(3), .BLANK_COLOUR(0))
        dut (.clock(clock), .resetn(resetn), .bus(bus.slave));
    // ROM mux model: registered on the falling edge, so data for the current address is ready by the next rising edge
    always @(negedge clock)
        bus.rom_data <= bus.rom_sel == 2'd0 ? bus.rom_addr[2:0] :
                        bus.rom_sel == 2'd1 ? ~bus.rom_addr[2:0] :
                        bus.rom_sel == 2'd2 ? 3'b010 : 3'b101;
    function automatic int exp_col(logic [1:0] s, int i);
        return s == 2'd0 ? i % 8 : s == 2'd1 ? 7 - i % 8 : s == 2'd2 ? 2 : 0;
    endfunction
    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic do_load(input logic [1:0] sel, input bit hold, input bit disturb,
                           output int plots, output int fin_at,
                           output int c00, output int c159, output int c160, output int clast);
        int idx;
        int busy_bad;
        idx = 0;
        busy_bad = 0;
        plots = 0;
        fin_at = -1;
        c00 = -1;
        c159 = -1;
        c160 = -1;
        clast = -1;
        bus.memory_select = sel;
        bus.start = 1'b1;
        @(negedge clock);
        if (!hold) bus.start = 1'b0;
        check("load_start_busy", int'(bus.busy), 1);
        check("load_start_plot", int'(bus.plot), 0);
        for (int j = 1; j <= N + 10 && fin_at < 0; j++) begin
            @(negedge clock);
            if (disturb && j == 500) begin
                bus.start = 1'b1;
                bus.memory_select = 2'd2;
            end
            if (disturb && j == 501) bus.start = 1'b0;
            if (int'(bus.busy) != (j <= N ? 1 : 0)) busy_bad++;
            if (bus.plot) begin
                checks++;
                if (int'(bus.x) != idx % 160 || int'(bus.y) != idx / 160 || int'(bus.colour) != exp_col(sel, idx)) begin
                    errors++;
                    if (pix_fail < 5)
                        $display("FAIL pixel %0d: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                                 idx, bus.x, bus.y, bus.colour, idx % 160, idx / 160, exp_col(sel, idx));
                    pix_fail++;
                end
                if (idx == 0) c00 = int'(bus.colour);
                if (idx == 159) c159 = int'(bus.colour);
                if (idx == 160) c160 = int'(bus.colour);
                if (idx == N - 1) clast = int'(bus.colour);
                idx++;
                plots++;
            end
            if (bus.finished) fin_at = j;
        end
        check("busy_profile_bad_cycles", busy_bad, 0);
    endtask
    typedef struct {
        logic [1:0] sel;
        bit         disturb;
        int         c00, c159, c160, clast;
    } vec_t;
    vec_t vecs[2];
    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int plots, fin_at, c00, c159, c160, clast, bad, fin_seen;
        bus.start = 1'b0;
        bus.memory_select = 2'd0;
        vecs[0] = '{2'd0, 1'b0, 0, 7, 0, 7};
        vecs[1] = '{2'd1, 1'b1, 7, 0, 7, 0};
        repeat (3) @(negedge clock);
        check("reset_plot", int'(bus.plot), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_finished", int'(bus.finished), 0);
        check("reset_rom_addr", int'(bus.rom_addr), 0);
        check("reset_rom_sel", int'(bus.rom_sel), 0);
        check("reset_xy_colour", int'({bus.x, bus.y, bus.colour}), 0);
        resetn = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (bus.plot || bus.busy || bus.finished || bus.rom_addr != 0) bad++;
        end
        check("idle_bad_cycles", bad, 0);
        foreach (vecs[i]) begin
            do_load(vecs[i].sel, 1'b0, vecs[i].disturb, plots, fin_at, c00, c159, c160, clast);
            check("tbl_plot_count", plots, N);
            check("tbl_finished_latency", fin_at, N + 1);
            check("tbl_rom_sel", int'(bus.rom_sel), int'(vecs[i].sel));
            check("tbl_rom_addr_end", int'(bus.rom_addr), N - 1);
            check("tbl_colour_0_0", c00, vecs[i].c00);
            check("tbl_colour_159_0", c159, vecs[i].c159);
            check("tbl_colour_0_1", c160, vecs[i].c160);
            check("tbl_colour_last", clast, vecs[i].clast);
            @(negedge clock);
            check("tbl_finished_width", int'(bus.finished), 0);
            check("tbl_idle_busy", int'(bus.busy), 0);
            check("tbl_idle_plot", int'(bus.plot), 0);
        end
        bus.memory_select = 2'd1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5000) @(negedge clock);
        check("midload_plot_before_reset", int'(bus.plot), 1);
        resetn = 1'b0;
        #1;
        check("midload_reset_plot", int'(bus.plot), 0);
        check("midload_reset_busy", int'(bus.busy), 0);
        check("midload_reset_rom_addr", int'(bus.rom_addr), 0);
        check("midload_reset_finished", int'(bus.finished), 0);
        fin_seen = 0;
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (bus.finished || bus.busy) fin_seen++;
        end
        check("midload_no_finished", fin_seen, 0);
        do_load(2'd3, 1'b1, 1'b0, plots, fin_at, c00, c159, c160, clast);
        check("b2b1_plot_count", plots, N);
        check("b2b1_finished_latency", fin_at, N + 1);
        check("b2b1_blank_last", clast, 0);
        bus.memory_select = 2'd2;
        @(negedge clock);
        check("b2b_idle_gap_busy", int'(bus.busy), 0);
        check("b2b_idle_gap_finished", int'(bus.finished), 0);
        do_load(2'd2, 1'b1, 1'b0, plots, fin_at, c00, c159, c160, clast);
        check("b2b2_plot_count", plots, N);
        check("b2b2_finished_latency", fin_at, N + 1);
        check("b2b2_rom_sel", int'(bus.rom_sel), 2);
        check("b2b2_colour_0_0", c00, 2);
        bus.start = 1'b0;
        @(negedge clock);
        check("b2b2_finished_width", int'(bus.finished), 0);
        @(negedge clock);
        check("final_idle_busy", int'(bus.busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
